// File: rtl/add_pipe_if.sv
// add_pipe_if: operand/result handshake bundle for add_pipe (ADD_PIPE_OVF_EN adds OVF)
interface add_pipe_if #(
  parameter int WIDTH = 32
);
  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             CI;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [WIDTH-1:0] S;
  logic             CO;
`ifdef ADD_PIPE_OVF_EN
  logic             OVF;
`endif
  modport slave (
    input  IN_VALID, A, B, CI, OUT_READY,
`ifdef ADD_PIPE_OVF_EN
    output OVF,
`endif
    output IN_READY, OUT_VALID, S, CO
  );
  modport master (
    output IN_VALID, A, B, CI, OUT_READY,
`ifdef ADD_PIPE_OVF_EN
    input  OVF,
`endif
    input  IN_READY, OUT_VALID, S, CO
  );
endinterface

// File: rtl/add_pipe.sv
// add_pipe: pipelined WIDTH-bit adder, one CHUNK-bit ripple slice per stage, valid/ready both ends
// Ports: CK clock; RST sync active-high reset; bus (add_pipe_if.slave):
//   IN_VALID/IN_READY/A/B/CI operand beat, OUT_VALID/OUT_READY/S/CO result beat.
// Define ADD_PIPE_OVF_EN to add the registered signed-overflow flag OVF to the result beat.
module add_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input logic       CK,
  input logic       RST,
  add_pipe_if.slave bus
);
  localparam int CHUNK = WIDTH / STAGES;
  localparam int L     = STAGES - 1;
  logic             v_q [STAGES];
  logic             v_d [STAGES];
  logic             c_q [STAGES];
  logic             c_d [STAGES];
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] a_d [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] b_d [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic [WIDTH-1:0] s_d [STAGES];
  // u_* is what feeds stage k: the bus for stage 0, stage k-1's registers otherwise
  logic             u_v [STAGES];
  logic             u_c [STAGES];
  logic [WIDTH-1:0] u_a [STAGES];
  logic [WIDTH-1:0] u_b [STAGES];
  logic [WIDTH-1:0] u_s [STAGES];
  logic [CHUNK:0]   sum [STAGES];
  logic             adv [STAGES];
  logic             ld  [STAGES];
`ifdef ADD_PIPE_OVF_EN
  logic             ovf_q;
  logic             ovf_d;
`endif
  always_comb begin
    u_v[0] = bus.IN_VALID;
    u_c[0] = bus.CI;
    u_a[0] = bus.A;
    u_b[0] = bus.B;
    u_s[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      u_v[k] = v_q[k-1];
      u_c[k] = c_q[k-1];
      u_a[k] = a_q[k-1];
      u_b[k] = b_q[k-1];
      u_s[k] = s_q[k-1];
    end
    // a stage may take a new beat when it is empty or its occupant moves on
    adv[L] = bus.OUT_READY | ~v_q[L];
    for (int k = L - 1; k >= 0; k--) adv[k] = adv[k+1] | ~v_q[k];
    for (int k = 0; k < STAGES; k++) begin
      ld[k]  = adv[k] & u_v[k];
      sum[k] = {1'b0, u_a[k][k*CHUNK +: CHUNK]} + {1'b0, u_b[k][k*CHUNK +: CHUNK]} + {{CHUNK{1'b0}}, u_c[k]};
      v_d[k] = adv[k] ? u_v[k] : v_q[k];
      a_d[k] = ld[k] ? u_a[k] : a_q[k];
      b_d[k] = ld[k] ? u_b[k] : b_q[k];
      c_d[k] = ld[k] ? sum[k][CHUNK] : c_q[k];
      s_d[k] = ld[k] ? u_s[k] : s_q[k];
      if (ld[k]) s_d[k][k*CHUNK +: CHUNK] = sum[k][CHUNK-1:0];
    end
`ifdef ADD_PIPE_OVF_EN
    // the last slice holds both operand MSBs and produces the sum MSB
    ovf_d = ld[L] ? ~(u_a[L][WIDTH-1] ^ u_b[L][WIDTH-1]) & (sum[L][CHUNK-1] ^ u_a[L][WIDTH-1]) : ovf_q;
`endif
  end
  always_ff @(posedge CK) begin
    if (RST) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= 1'b0;
        c_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
`ifdef ADD_PIPE_OVF_EN
      ovf_q <= 1'b0;
`endif
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= v_d[k];
        c_q[k] <= c_d[k];
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
      end
`ifdef ADD_PIPE_OVF_EN
      ovf_q <= ovf_d;
`endif
    end
  end
  assign bus.IN_READY  = adv[0];
  assign bus.OUT_VALID = v_q[L];
  assign bus.S         = s_q[L];
  assign bus.CO        = c_q[L];
`ifdef ADD_PIPE_OVF_EN
  assign bus.OVF       = ovf_q;
`endif
endmodule

// File: tb/tb_add_pipe.sv
// tb_add_pipe: random + directed scoreboard bench for add_pipe against an arithmetic reference
module tb_add_pipe;
  localparam int WIDTH  = 32;
  localparam int STAGES = 4;
  localparam longint SMAX = (longint'(1) <<< (WIDTH - 1)) - 1;
  localparam longint SMIN = -(longint'(1) <<< (WIDTH - 1));
  typedef struct {
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ovf;
    int               cyc;
  } exp_t;
  logic CK = 1'b0;
  logic RST = 1'b1;
  logic rnd_rdy = 1'b0;
  logic rr = 1'b1;
  logic or_fix = 1'b1;
  logic lat_on = 1'b0;
  int cyc = 0;
  int checks = 0;
  int passes = 0;
  exp_t sb[$];
  exp_t e;
  add_pipe_if #(.WIDTH(WIDTH)) bus ();
  add_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (.CK(CK), .RST(RST), .bus(bus.slave));
  assign bus.OUT_READY = rnd_rdy ? rr : or_fix;
  always #5 CK = ~CK;
  always @(posedge CK) cyc <= cyc + 1;
  initial forever begin
    @(posedge CK);
    #1 rr = ($urandom_range(0, 3) != 0);
  end
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic ci);
    exp_t r;
    longint unsigned u;
    longint sg;
    u = 64'(a) + 64'(b) + 64'(ci);
    sg = longint'($signed(a)) + longint'($signed(b)) + longint'(ci);
    r.s = u[WIDTH-1:0];
    r.co = u[WIDTH];
    r.ovf = (sg > SMAX) || (sg < SMIN);
    r.cyc = cyc;
    return r;
  endfunction
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic ci);
    int t = 0;
    bus.IN_VALID = 1'b1;
    bus.A = a;
    bus.B = b;
    bus.CI = ci;
    @(negedge CK);
    while (!bus.IN_READY && t < 300) begin
      @(negedge CK);
      t++;
    end
    if (bus.IN_READY) sb.push_back(model(a, b, ci));
    else begin
      checks++;
      $display("FAIL in_ready_timeout: got IN_READY=0 for %0d cycles, expected acceptance", t);
    end
    @(posedge CK);
    #1;
    bus.IN_VALID = 1'b0;
    bus.A = $urandom;
    bus.B = $urandom;
    bus.CI = 1'($urandom_range(0, 1));
  endtask
  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 500) begin
      @(negedge CK);
      t++;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
    @(posedge CK);
    #1;
  endtask
  always @(negedge CK) begin
    if (!RST && bus.OUT_VALID && bus.OUT_READY) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL out_without_beat: got OUT_VALID=1 S=0x%0h, expected no output", bus.S);
      end else begin
        e = sb.pop_front();
        check("S", 64'(bus.S), 64'(e.s));
        check("CO", 64'(bus.CO), 64'(e.co));
`ifdef ADD_PIPE_OVF_EN
        check("OVF", 64'(bus.OVF), 64'(e.ovf));
`endif
        if (lat_on) check("latency", 64'(cyc - e.cyc), 64'(STAGES));
      end
    end
  end
  initial begin
    int n;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    bus.IN_VALID = 1'b0;
    bus.A = '0;
    bus.B = '0;
    bus.CI = 1'b0;
    repeat (3) @(posedge CK);
    #1 RST = 1'b0;
    @(negedge CK);
    check("rst_out_valid", 64'(bus.OUT_VALID), 64'd0);
    check("rst_s", 64'(bus.S), 64'd0);
    check("rst_co", 64'(bus.CO), 64'd0);
    check("rst_in_ready", 64'(bus.IN_READY), 64'd1);
`ifdef ADD_PIPE_OVF_EN
    check("rst_ovf", 64'(bus.OVF), 64'd0);
`endif
    @(posedge CK);
    #1;
    lat_on = 1'b1;
    send(32'hFFFF_FFFF, 32'h1, 1'b0);
    drain();
    send(32'h0, 32'h0, 1'b1);
    send(32'h0000_FFFF, 32'h1, 1'b1);
    drain();
    send(32'h1, 32'h2, 1'b0);
    send(32'h3, 32'h4, 1'b0);
    send(32'h8000_0000, 32'h8000_0000, 1'b0);
    drain();
    lat_on = 1'b0;
    or_fix = 1'b0;
    for (int i = 0; i < STAGES; i++) send(32'(i), 32'h10, 1'b0);
    bus.IN_VALID = 1'b1;
    bus.A = 32'(STAGES);
    bus.B = 32'h10;
    bus.CI = 1'b0;
    repeat (3) begin
      @(negedge CK);
      check("full_in_ready", 64'(bus.IN_READY), 64'd0);
      check("stall_valid", 64'(bus.OUT_VALID), 64'd1);
      check("stall_s", 64'(bus.S), 64'h10);
      check("stall_co", 64'(bus.CO), 64'd0);
    end
    @(posedge CK);
    #1 or_fix = 1'b1;
    for (int i = STAGES; i < 2 * STAGES; i++) send(32'(i), 32'h10, 1'b0);
    drain();
    lat_on = 1'b1;
    send(32'h1234_5678, 32'h1111_1111, 1'b0);
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    RST = 1'b1;
    @(posedge CK);
    #1 RST = 1'b0;
    sb.delete();
    @(negedge CK);
    check("midrst_out_valid", 64'(bus.OUT_VALID), 64'd0);
    check("midrst_s", 64'(bus.S), 64'd0);
    check("midrst_co", 64'(bus.CO), 64'd0);
    check("midrst_in_ready", 64'(bus.IN_READY), 64'd1);
    n = 0;
    repeat (8) begin
      @(negedge CK);
      if (bus.OUT_VALID) n++;
    end
    check("midrst_no_ghosts", 64'(n), 64'd0);
    @(posedge CK);
    #1;
    send(32'h7FFF_FFFF, 32'h1, 1'b0);
    send(32'hFFFF_FFFF, 32'h1, 1'b0);
    send(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    drain();
    lat_on = 1'b0;
    rnd_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      a = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 32'h0000_0001 : 32'($urandom);
      send(a, b, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge CK);
        #1;
      end
    end
    rnd_rdy = 1'b0;
    drain();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
